// File: rtl/xbar_out_port_pkg.sv
// Shared NoC definitions: flit type codes and where the type field sits in a flit.
package xbar_out_port_pkg;

  localparam int FLIT_TYPE_W = 2;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_TAIL      = 2'b01,
    FLIT_HEAD      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  // The type field always occupies the top FLIT_TYPE_W bits of a flit.
  function automatic int type_lsb(int flit_w);
    return flit_w - FLIT_TYPE_W;
  endfunction

  function automatic logic opens_packet(flit_type_e t);
    return t[1];
  endfunction

endpackage

// File: rtl/matrix_arb.sv
// Matrix round-robin arbiter with binary grant; priority moves only on update_i.
module matrix_arb #(
  parameter int N = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 update_i,
  output logic [$clog2(N)-1:0] grant_o
);

  localparam int W     = $clog2(N);
  localparam int PAIRS = N * (N - 1) / 2;

  // One bit per unordered pair (i<j), set when i outranks j.
  logic [PAIRS-1:0] prio;
  logic [N-1:0]     win;

  function automatic int pidx(int i, int j);
    return i * N - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic logic beats(logic [PAIRS-1:0] p, int a, int b);
    if (a < b) return p[pidx(a, b)];
    else       return ~p[pidx(b, a)];
  endfunction

  always_comb begin
    win = req_i;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && req_i[j] && beats(prio, j, i)) win[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) grant_o = grant_o | W'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio <= '1;
    end else if (update_i) begin
      for (int i = 0; i < N; i++) begin
        for (int j = i + 1; j < N; j++) begin
          if (grant_o == W'(i))      prio[pidx(i, j)] <= 1'b0;
          else if (grant_o == W'(j)) prio[pidx(i, j)] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xbar_out_port.sv
// Crossbar output port: arbitrates packet heads, holds the output for multi-flit
// packets and registers the selected flit toward downstream.
module xbar_out_port
  import xbar_out_port_pkg::*;
#(
  parameter int IN_N   = 5,
  parameter int FLIT_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [IN_N*FLIT_W-1:0]  data_i,
  input  logic [IN_N-1:0]         valid_i,
  output logic [IN_N-1:0]         ready_o,
  output logic [FLIT_W-1:0]       data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic [$clog2(IN_N)-1:0] owner_o
);

  localparam int IDX_W    = $clog2(IN_N);
  localparam int TYPE_LSB = type_lsb(FLIT_W);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e           state, state_next;
  logic             out_en;
  logic [IN_N-1:0]  req;
  logic             any_req;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] sel;
  logic [FLIT_W-1:0] sel_flit;
  flit_type_e       sel_type;
  logic             head_xfer;
  logic             xfer;

  assign out_en = ~valid_o | ready_i;

  always_comb begin
    req = '0;
    for (int k = 0; k < IN_N; k++) begin
      req[k] = (state == ST_IDLE) & valid_i[k] & out_en &
               opens_packet(flit_type_e'(data_i[k*FLIT_W + TYPE_LSB +: FLIT_TYPE_W]));
    end
  end

  assign any_req   = |req;
  assign head_xfer = (state == ST_IDLE) & any_req;

  matrix_arb #(.N(IN_N)) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .update_i (head_xfer),
    .grant_o  (grant)
  );

  assign sel = (state == ST_LOCKED) ? owner_o : grant;

  always_comb begin
    sel_flit = '0;
    for (int k = 0; k < IN_N; k++) begin
      if (sel == IDX_W'(k)) sel_flit = data_i[k*FLIT_W +: FLIT_W];
    end
  end

  assign sel_type = flit_type_e'(sel_flit[TYPE_LSB +: FLIT_TYPE_W]);

  // Only the selected input may ever see ready; in IDLE it also needs a winning head.
  always_comb begin
    ready_o = '0;
    for (int k = 0; k < IN_N; k++) begin
      if (sel == IDX_W'(k)) ready_o[k] = (state == ST_LOCKED) ? out_en : any_req;
    end
  end

  assign xfer = |(valid_i & ready_o);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (head_xfer && sel_type == FLIT_HEAD) state_next = ST_LOCKED;
      ST_LOCKED: if (xfer && sel_type == FLIT_TAIL)      state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      owner_o <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      state <= state_next;
      if (head_xfer) owner_o <= grant;
      if (out_en) begin
        valid_o <= xfer;
        if (xfer) data_o <= sel_flit;
      end
    end
  end

  assign busy_o = (state == ST_LOCKED);

endmodule

// File: tb/tb_xbar_out_port.sv
// Randomised bench for xbar_out_port: priority-list reference model, output scoreboard.
module tb_xbar_out_port;
  import xbar_out_port_pkg::*;

  localparam int IN_N   = 5;
  localparam int FLIT_W = 10;
  localparam int IDX_W  = 3;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [IN_N*FLIT_W-1:0] data_i;
  logic [IN_N-1:0]        valid_i;
  logic [IN_N-1:0]        ready_o;
  logic [FLIT_W-1:0]      data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic                   busy_o;
  logic [IDX_W-1:0]       owner_o;

  xbar_out_port #(.IN_N(IN_N), .FLIT_W(FLIT_W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .owner_o (owner_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [FLIT_W-1:0] src_q [IN_N][$];
  logic [FLIT_W-1:0] exp_q [$];
  int                prio_q [$];
  bit                m_valid, m_locked;
  int                m_owner;

  bit [IN_N-1:0] stall_mask = '0;
  int            stall_pct  = 0;
  int            rdy_pct    = 100;
  bit            force_rdy_low = 0;
  bit            rand_gen   = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(logic [1:0] t);
    return {t, 8'($urandom)};
  endfunction

  task automatic load_pkt(int k, int len);
    if (len == 1) begin
      src_q[k].push_back(mk_flit(FLIT_HEAD_TAIL));
    end else begin
      src_q[k].push_back(mk_flit(FLIT_HEAD));
      for (int b = 0; b < len - 2; b++) src_q[k].push_back(mk_flit(FLIT_BODY));
      src_q[k].push_back(mk_flit(FLIT_TAIL));
    end
  endtask

  task automatic model_reset();
    m_valid  = 0;
    m_locked = 0;
    m_owner  = 0;
    prio_q.delete();
    for (int k = 0; k < IN_N; k++) prio_q.push_back(k);
    exp_q.delete();
    for (int k = 0; k < IN_N; k++) src_q[k].delete();
  endtask

  task automatic run_cycle();
    bit                out_en;
    int                acc;
    logic [IN_N-1:0]   exp_rdy;
    logic [FLIT_W-1:0] f;
    @(negedge clk_i);
    if (rand_gen) begin
      for (int k = 0; k < IN_N; k++)
        if (src_q[k].size() == 0 && $urandom_range(99) < 30) load_pkt(k, $urandom_range(1, 5));
    end
    for (int k = 0; k < IN_N; k++) begin
      bit stall;
      stall = stall_mask[k] || ($urandom_range(99) < stall_pct);
      valid_i[k] = (src_q[k].size() > 0) && !stall;
      data_i[k*FLIT_W +: FLIT_W] = valid_i[k] ? src_q[k][0] : FLIT_W'($urandom);
    end
    ready_i = !force_rdy_low && ($urandom_range(99) < rdy_pct);
    #1;
    // Reference: a locked owner keeps the port; otherwise first head-offering input in priority order.
    out_en  = !m_valid || ready_i;
    acc     = -1;
    exp_rdy = '0;
    if (m_locked) begin
      exp_rdy[m_owner] = out_en;
      if (out_en && valid_i[m_owner]) acc = m_owner;
    end else if (out_en) begin
      foreach (prio_q[i]) begin
        int p;
        p = prio_q[i];
        if (acc < 0 && valid_i[p] && src_q[p][0][FLIT_W-1]) acc = p;
      end
      if (acc >= 0) exp_rdy[acc] = 1'b1;
    end
    check("ready_o", ready_o, exp_rdy);
    check("busy_o",  busy_o,  m_locked);
    check("owner_o", owner_o, m_owner);
    check("valid_o", valid_o, m_valid);
    @(posedge clk_i);
    if (acc >= 0) begin
      f = src_q[acc].pop_front();
      exp_q.push_back(f);
      if (!m_locked) begin
        m_owner = acc;
        foreach (prio_q[i]) if (prio_q[i] == acc) begin prio_q.delete(i); break; end
        prio_q.push_back(acc);
        if (f[FLIT_W-1 -: 2] == FLIT_HEAD) m_locked = 1;
      end else if (f[FLIT_W-1 -: 2] == FLIT_TAIL) begin
        m_locked = 0;
      end
    end
    if (out_en) m_valid = (acc >= 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_busy_o",  busy_o,  0);
    check("rst_owner_o", owner_o, 0);
    check("rst_data_o",  data_o,  0);
    model_reset();
    valid_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic bit pending();
    bit p;
    p = exp_q.size() > 0;
    for (int k = 0; k < IN_N; k++) if (src_q[k].size() > 0) p = 1;
    return p;
  endfunction

  // Output monitor: every flit leaving the port must be the next one accepted.
  initial begin
    logic [FLIT_W-1:0] e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL data_o: got %0h expected nothing (unexpected flit) at %0t", data_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("data_o", data_o, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_ni  = 1'b0;
    valid_i = '0;
    ready_i = 1'b0;
    data_i  = '0;
    model_reset();
    do_reset();

    // One single-flit packet per input, all offered together.
    for (int k = 0; k < IN_N; k++) load_pkt(k, 1);
    repeat (8) run_cycle();

    // Input 2 holds the port for four flits while input 1 waits with a head.
    load_pkt(2, 4);
    run_cycle();
    load_pkt(1, 2);
    repeat (10) run_cycle();

    // Downstream stall in the middle of a packet.
    load_pkt(4, 6);
    repeat (2) run_cycle();
    force_rdy_low = 1;
    repeat (3) run_cycle();
    force_rdy_low = 0;
    repeat (8) run_cycle();

    // Stray body flit while idle must just sit there.
    src_q[3].push_back(mk_flit(FLIT_BODY));
    repeat (3) run_cycle();
    src_q[3].delete();
    run_cycle();

    // Owner goes quiet mid-packet while input 0 offers a head.
    load_pkt(1, 5);
    repeat (2) run_cycle();
    stall_mask[1] = 1;
    load_pkt(0, 1);
    repeat (5) run_cycle();
    stall_mask[1] = 0;
    repeat (10) run_cycle();

    // Reset while locked with a flit in the output register.
    load_pkt(2, 8);
    cnt = 0;
    while (!(m_locked && m_valid) && cnt < 20) begin
      run_cycle();
      cnt++;
    end
    if (cnt >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL lock_wait: got no lock after %0d cycles expected lock", cnt);
    end
    do_reset();
    load_pkt(2, 1);
    load_pkt(1, 1);
    load_pkt(0, 1);
    repeat (6) run_cycle();

    // Random traffic with input stalls and downstream back-pressure.
    rand_gen  = 1;
    stall_pct = 25;
    rdy_pct   = 70;
    repeat (1500) run_cycle();

    rand_gen  = 0;
    stall_pct = 0;
    rdy_pct   = 100;
    cnt = 0;
    while (pending() && cnt < 300) begin
      run_cycle();
      cnt++;
    end
    check("drain_exp_q", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xbar_out_port.md
XBAR_OUT_PORT -- requirements
Module: xbar_out_port

Interface
REQ-001 SHALL have parameter IN_N, default 5: number of input ports competing for this output.
REQ-002 SHALL have parameter FLIT_W, default 10: flit width; bits [FLIT_W-1:FLIT_W-2] are the flit type.
REQ-003 SHALL have port clk_i, input, 1: clock, all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port data_i, input, IN_N*FLIT_W: input flits; input k occupies bits [k*FLIT_W +: FLIT_W].
REQ-006 SHALL have port valid_i, input, IN_N: per-input flit valid.
REQ-007 SHALL have port ready_o, output, IN_N: per-input accept; a transfer on input k is valid_i[k] & ready_o[k].
REQ-008 SHALL have port data_o, output, FLIT_W: registered output flit.
REQ-009 SHALL have port valid_o, output, 1: registered output valid.
REQ-010 SHALL have port ready_i, input, 1: downstream accept; an output transfer is valid_o & ready_i.
REQ-011 SHALL have port busy_o, output, 1: high while a multi-flit packet holds the output.
REQ-012 SHALL have port owner_o, output, $clog2(IN_N): index of the input holding or last holding the output.

Function
REQ-013 Flit types SHALL be: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
REQ-014 Output register enable SHALL be out_en = ~valid_o | ready_i; the register loads only when out_en=1.
REQ-015 FSM SHALL have two states, IDLE and LOCKED; busy_o = (state == LOCKED).
REQ-016 In IDLE, arbitration requests SHALL be req[k] = valid_i[k] & type_k is HEAD or HEAD_TAIL & out_en.
REQ-017 In IDLE, BODY/TAIL flits SHALL NOT request; their ready_o stays 0 (stall, no drop).
REQ-018 In IDLE with any req set, exactly the granted input g SHALL see ready_o[g]=1; all other ready_o SHALL be 0.
REQ-019 Arbitration SHALL be round-robin with strong fairness: the granted input drops to lowest priority, and priority SHALL update only in cycles where a head transfer occurs.
REQ-020 On a HEAD transfer from g in IDLE, the FSM SHALL go to LOCKED and owner_o SHALL become g.
REQ-021 On a HEAD_TAIL transfer from g in IDLE, the FSM SHALL stay IDLE and owner_o SHALL become g.
REQ-022 In LOCKED, ready_o[owner] SHALL equal out_en; every other ready_o SHALL be 0; no arbitration SHALL occur.
REQ-023 In LOCKED, a TAIL transfer from the owner SHALL return the FSM to IDLE on the next edge; BODY/HEAD keep LOCKED.
REQ-024 The FSM SHALL leave LOCKED only on the owner's TAIL transfer, however long the owner stalls (valid_i low).
REQ-025 An accepted input flit SHALL appear on data_o with valid_o=1 on the next cycle (latency 1), unmodified.
REQ-026 If out_en=1 and no input transfers, valid_o SHALL go to 0 next cycle; data_o MAY hold its old value.
REQ-027 While valid_o=1 and ready_i=0, data_o and valid_o SHALL hold and all ready_o SHALL be 0.
REQ-028 Full throughput SHALL be sustained: with ready_i=1 and owner valid_i=1, one flit per cycle.
REQ-029 After a TAIL transfer, a new HEAD MAY be granted no earlier than the following cycle (one-cycle arbitration bubble).

Reset
REQ-030 On rst_ni low, SHALL asynchronously set valid_o=0, data_o=0, state=IDLE, busy_o=0, owner_o=0.
REQ-031 Reset SHALL restore arbiter priority to fixed order, input 0 highest, input IN_N-1 lowest.
REQ-032 Reset mid-packet SHALL drop the lock; after release the FSM waits in IDLE for a HEAD.

Structure
REQ-033 Flit type codes and the FLIT_W type-field position SHALL live in a shared NoC package reused by input buffers and routers.
REQ-034 Arbitration SHALL be delegated to one sub-module, the existing matrix_arb (req_i, binary grant_o), with any-request qualifying the grant.
REQ-035 The data path SHALL be an IN_N:1 mux selected by grant in IDLE and by owner in LOCKED, feeding the output register.

Verification
REQ-036 Reset, then HEAD_TAIL on inputs 0..4 all valid, ready_i=1 -> owner_o sequence 0,1,2,3,4; one flit out per cycle.
REQ-037 Input 2 sends HEAD,BODY,BODY,TAIL while input 1 holds a HEAD -> 4 flits from 2 contiguous on data_o; input 1 ready_o=0 until the cycle after the TAIL transfer.
REQ-038 ready_i=0 for 3 cycles mid-packet -> data_o/valid_o stable, all ready_o=0, no flit lost or duplicated.
REQ-039 BODY flit on input 3 while IDLE -> ready_o[3]=0, valid_o=0, busy_o=0.
REQ-040 Owner drops valid_i for 5 cycles mid-packet while input 0 offers a HEAD -> busy_o=1 throughout, input 0 not granted.
REQ-041 Assert rst_ni=0 while LOCKED with valid_o=1 -> valid_o=0 and busy_o=0 immediately; input 0 wins the first arbitration after release.
